// File: rtl/seq_detect_prog_if.sv
// Symbol stream, pattern-programming and match-event bundle for seq_detect_prog.
// Master drives symbols and configuration, and the slave (the detector) drives status.
// Widths follow the detector parameters so that one instance fits one detector.
interface seq_detect_prog_if #(
  parameter int SYM_W = 2,
  parameter int IDX_W = 2,
  parameter int CNT_W = 8
);
  logic [SYM_W-1:0] s;
  logic             s_valid;
  logic             mode_restart;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_addr;
  logic [SYM_W-1:0] cfg_val;
  logic [SYM_W-1:0] cfg_mask;
  logic             cfg_op;
  logic             cfg_len_we;
  logic [IDX_W:0]   cfg_len;
  logic [IDX_W-1:0] state;
  logic             match;
  logic             timeout;
  logic [CNT_W-1:0] match_count;

  modport master (
    output s, s_valid, mode_restart, cfg_we, cfg_addr, cfg_val, cfg_mask, cfg_op,
           cfg_len_we, cfg_len,
    input  state, match, timeout, match_count
  );

  modport slave (
    input  s, s_valid, mode_restart, cfg_we, cfg_addr, cfg_val, cfg_mask, cfg_op,
           cfg_len_we, cfg_len,
    output state, match, timeout, match_count
  );
endinterface

// File: rtl/seq_detect_prog.sv
// Programmable masked/nonzero symbol-sequence detector with a saturating match counter.
// match and timeout are registered, so they pulse in the cycle after the deciding edge.
// There is no backpressure: every s_valid symbol is consumed, and config writes pre-empt that cycle's symbol.
module seq_detect_prog #(
  parameter int SYM_W   = 2,
  parameter int DEPTH   = 4,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 8
) (
  input logic              clk,
  input logic              res,
  seq_detect_prog_if.slave bus
);
  localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [IDX_W:0]  LEN_MIN = (IDX_W+1)'(2);
  localparam logic [IDX_W:0]  LEN_MAX = (IDX_W+1)'(DEPTH);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  // pattern storage
  logic [SYM_W-1:0] val_q  [DEPTH];
  logic [SYM_W-1:0] mask_q [DEPTH];
  logic [DEPTH-1:0] op_q;
  logic [IDX_W:0]   len_q;
  logic [IDX_W:0]   len_wr;

  // sequencing state
  logic [IDX_W-1:0] state_q, state_d;
  logic             match_q, match_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]  idle_q, idle_d;

  logic cfg_any;
  logic at_last;

  // A step hits on a masked equality, or on any nonzero symbol for NONZERO steps.
  function automatic logic step_hit(input logic [IDX_W-1:0] idx, input logic [SYM_W-1:0] sym);
    if (op_q[idx]) return sym != '0;
    return ((sym ^ val_q[idx]) & mask_q[idx]) == '0;
  endfunction

  assign cfg_any = bus.cfg_we | bus.cfg_len_we;
  assign at_last = ({1'b0, state_q} == (len_q - (IDX_W+1)'(1)));

  // Clamp the requested length into the legal 2..DEPTH window.
  always_comb begin
    len_wr = bus.cfg_len;
    if (bus.cfg_len < LEN_MIN)      len_wr = LEN_MIN;
    else if (bus.cfg_len > LEN_MAX) len_wr = LEN_MAX;
  end

  // Pattern registers: written by software and restored to "match zero on every step" at reset.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int i = 0; i < DEPTH; i++) begin
        val_q[i]  <= '0;
        mask_q[i] <= '1;
      end
      op_q  <= '0;
      len_q <= LEN_MAX;
    end else begin
      if (bus.cfg_we && (int'(bus.cfg_addr) < DEPTH)) begin
        val_q[bus.cfg_addr]  <= bus.cfg_val;
        mask_q[bus.cfg_addr] <= bus.cfg_mask;
        op_q[bus.cfg_addr]   <= bus.cfg_op;
      end
      if (bus.cfg_len_we) len_q <= len_wr;
    end
  end

  // Next step index, event pulses, match count and idle tracking, in priority order.
  always_comb begin
    state_d   = state_q;
    match_d   = 1'b0;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    idle_d    = idle_q;
    if (cfg_any) begin
      // A pattern change invalidates any partial progress.
      state_d = '0;
      idle_d  = '0;
    end else if (bus.s_valid) begin
      idle_d = '0;
      if (step_hit(state_q, bus.s)) begin
        if (at_last) begin
          state_d = '0;
          match_d = 1'b1;
          cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        end else begin
          state_d = state_q + IDX_W'(1);
        end
      end else if (bus.mode_restart) begin
        // The missed symbol may itself start a fresh attempt at step 0.
        state_d = step_hit('0, bus.s) ? IDX_W'(1) : '0;
      end
    end else if ((state_q != '0) && (TIMEOUT != 0)) begin
      if (idle_q == TO_LAST) begin
        state_d   = '0;
        timeout_d = 1'b1;
        idle_d    = '0;
      end else begin
        idle_d = idle_q + TO_W'(1);
      end
    end else begin
      idle_d = '0;
    end
  end

  // Sequencing registers; reset aborts progress and kills an in-flight pulse.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q   <= '0;
      match_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      idle_q    <= '0;
    end else begin
      state_q   <= state_d;
      match_q   <= match_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      idle_q    <= idle_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.match       = match_q;
  assign bus.timeout     = timeout_q;
  assign bus.match_count = cnt_q;
endmodule
